// File: rtl/mem_write_capture.sv
// mem_write_capture: snoops core data-memory writes, captures in-window writes into a FIFO
// drained over valid/ready, and flags sticky done/overflow with a saturating drop counter.
module mem_write_capture #(
    parameter logic [31:0] ADDR_BASE = 32'd96,
    parameter logic [31:0] ADDR_SPAN = 32'd16,
    parameter logic [31:0] DONE_ADDR = 32'd100,
    parameter logic [31:0] DONE_DATA = 32'd7,
    parameter int          DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [31:0]              rd_addr,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0] mem_addr [DEPTH];
    logic [31:0] mem_data [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic hit, pop, full, push, drop, done_hit;
    always_comb begin
        // 33-bit compare keeps the window end from wrapping
        hit      = MemWrite && (DataAdr >= ADDR_BASE) &&
                   ({1'b0, DataAdr} < ({1'b0, ADDR_BASE} + {1'b0, ADDR_SPAN}));
        count    = wr_ptr - rd_ptr;
        rd_valid = count != '0;
        full     = count == (AW+1)'(DEPTH);
        pop      = rd_valid && rd_ready;
        push     = hit && !done && (!full || pop);
        drop     = hit && !done && full && !pop;
        done_hit = MemWrite && (DataAdr == DONE_ADDR) && (WriteData == DONE_DATA);
        rd_addr  = rd_valid ? mem_addr[rd_ptr[AW-1:0]] : '0;
        rd_data  = rd_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (done_hit) done <= 1'b1;
            if (drop) overflow <= 1'b1;
            if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr[AW-1:0]] <= DataAdr;
            mem_data[wr_ptr[AW-1:0]] <= WriteData;
        end
    end
endmodule

// File: tb/tb_mem_write_capture.sv
// tb_mem_write_capture: vector table plus queue scoreboard against an independent FIFO/window model.
module tb_mem_write_capture;
    logic        clk = 0, reset = 0, MemWrite = 0, rd_ready = 0;
    logic [31:0] DataAdr = 0, WriteData = 0;
    logic        rd_valid, done, overflow;
    logic [31:0] rd_addr, rd_data;
    logic [3:0]  count;
    logic [7:0]  drop_count;

    mem_write_capture dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .done(done),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    typedef struct { logic mw; logic [31:0] a; logic [31:0] d; int exp_count; } vec_t;

    ent_t sb[$];
    logic m_done = 0, m_ovf = 0;
    int   m_drops = 0;
    int   total = 0, passed = 0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    endtask

    task automatic chk_state(input string n);
        check({n, "_count"}, 32'(count), 32'(sb.size()));
        check({n, "_valid"}, 32'(rd_valid), 32'(sb.size() != 0));
        check({n, "_done"}, 32'(done), 32'(m_done));
        check({n, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check({n, "_drops"}, 32'(drop_count), 32'(m_drops));
        if (sb.size() == 0) begin
            check({n, "_addr0"}, rd_addr, 32'd0);
            check({n, "_data0"}, rd_data, 32'd0);
        end
    endtask

    task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        logic hit, pop, full;
        ent_t e;
        MemWrite = mw; DataAdr = a; WriteData = d; rd_ready = rdy;
        #1;
        pop  = rdy && sb.size() != 0;
        full = sb.size() == 8;
        hit  = mw && a >= 32'd96 && a < 32'd112;
        if (pop) begin
            check("pop_valid", 32'(rd_valid), 32'd1);
            check("pop_addr", rd_addr, sb[0].a);
            check("pop_data", rd_data, sb[0].d);
        end
        @(posedge clk);
        if (pop) void'(sb.pop_front());
        if (hit && !m_done) begin
            if (!full || pop) begin
                e.a = a; e.d = d;
                sb.push_back(e);
            end else begin
                m_ovf = 1;
                if (m_drops != 255) m_drops++;
            end
        end
        if (mw && a == 32'd100 && d == 32'd7) m_done = 1;
        #1;
        MemWrite = 0; DataAdr = 'x; WriteData = 'x; rd_ready = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) cyc(0, 0, 0, 1);
        check("drain_empty", 32'(count), 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 0;
        sb.delete(); m_done = 0; m_ovf = 0; m_drops = 0;
        @(posedge clk); #1;
        reset = 1;
    endtask

    vec_t tv[8];

    initial begin
        tv[0] = '{1, 32'd96,  32'h11, 1};
        tv[1] = '{1, 32'd104, 32'h22, 2};
        tv[2] = '{1, 32'd200, 32'h33, 2};
        tv[3] = '{0, 32'd100, 32'h7,  2};
        tv[4] = '{1, 32'd95,  32'h1,  2};
        tv[5] = '{1, 32'd111, 32'h55, 3};
        tv[6] = '{1, 32'd112, 32'h2,  3};
        tv[7] = '{1, 32'd100, 32'h5,  4};

        do_reset();
        @(posedge clk); #1;
        chk_state("reset");

        for (int i = 0; i < 8; i++) begin
            cyc(tv[i].mw, tv[i].a, tv[i].d, 0);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(tv[i].exp_count));
            chk_state($sformatf("vec%0d", i));
        end
        check("head_addr", rd_addr, 32'd96);
        check("head_data", rd_data, 32'h11);
        cyc(0, 0, 0, 0);
        check("hold_addr", rd_addr, 32'd96);
        drain();
        chk_state("after_drain");

        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 32'd96 + 32'((i % 4) * 4), 32'(i + 8'h40), 0);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd2);
        chk_state("ovf");
        drain();

        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 32'd108, 32'(i), 0);
        cyc(1, 32'd108, 32'hAA, 1);
        check("fullpp_count", 32'(count), 32'd8);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        chk_state("fullpp");
        for (int i = 0; i < 5; i++) cyc(1, 32'd104, 32'(i + 32'h100), 1);
        drain();

        do_reset();
        for (int i = 0; i < 270; i++) cyc(1, 32'd97, 32'(i), 0);
        check("sat_drops", 32'(drop_count), 32'd255);
        chk_state("sat");
        drain();

        do_reset();
        cyc(1, 32'd100, 32'd5, 0);
        check("done_wrongdata", 32'(done), 32'd0);
        cyc(1, 32'd100, 32'd7, 0);
        check("done_set", 32'(done), 32'd1);
        cyc(1, 32'd108, 32'h44, 0);
        check("done_count", 32'(count), 32'd2);
        check("done_drops", 32'(drop_count), 32'd0);
        chk_state("done");
        drain();
        check("done_sticky", 32'(done), 32'd1);

        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 32'd96 + 32'(i * 4), 32'(i), 0);
        cyc(0, 0, 0, 1);
        check("mid_count", 32'(count), 32'd3);
        cyc(1, 32'd100, 32'd7, 0);
        #2;
        reset = 0;
        sb.delete(); m_done = 0; m_ovf = 0; m_drops = 0;
        #1;
        chk_state("async_rst");
        @(posedge clk); #1;
        reset = 1;
        cyc(1, 32'd104, 32'h99, 0);
        chk_state("post_rst");
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
